// File: rtl/atax_operand_packer_if.sv
// Stream-in / frame-out bus of the atax operand packer.
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1. A source that raises valid keeps it, and
// keeps its payload stable, until that transfer. ready may change freely.
interface atax_operand_packer_if #(
  parameter int WORD_W  = 32,
  parameter int A_WORDS = 16,
  parameter int X_WORDS = 2
) ();
  logic                        s_valid;
  logic                        s_ready;
  logic [WORD_W-1:0]           s_data;
  logic                        s_last;
  logic                        m_valid;
  logic                        m_ready;
  logic [A_WORDS*WORD_W-1:0]   m_A;
  logic [X_WORDS*WORD_W-1:0]   m_x;

  // Environment side: drives the word stream and the frame-accept ready.
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_A, m_x
  );

  // Packer side.
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_A, m_x
  );
endinterface

// File: rtl/atax_operand_packer.sv
// Assembles a serial word stream into one A/x operand frame for the atax core.
// An assembly buffer collects frame n+1 while the output register holds frame n
// until the core accepts it (core enable = m_valid & m_ready).
module atax_operand_packer #(
  parameter int WORD_W  = 32,
  parameter int A_WORDS = 16,
  parameter int X_WORDS = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  atax_operand_packer_if.slave bus,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err,
  input  logic             clr_err,
  output logic             dbg_state
);

  localparam int F      = A_WORDS + X_WORDS;
  localparam int WCNT_W = $clog2(F);
  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(F - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
  logic [A_WORDS*WORD_W-1:0] asm_a_q, asm_a_d;
  logic [X_WORDS*WORD_W-1:0] asm_x_q, asm_x_d;
  logic [A_WORDS*WORD_W-1:0] out_a_q, out_a_d;
  logic [X_WORDS*WORD_W-1:0] out_x_q, out_x_d;
  logic                      m_valid_q, m_valid_d;
  logic [CNT_W-1:0]          frame_cnt_q, frame_cnt_d;
  logic                      err_q, err_d;

  logic s_ready;
  logic beat;
  logic drain;
  logic at_last;
  logic err_set;

  // Ready is gated by reset so the producer sees 0 while reset is held.
  assign s_ready = (state_q == COLLECT) && reset;
  assign beat    = bus.s_valid && s_ready;
  assign drain   = m_valid_q && bus.m_ready;
  assign at_last = (wcnt_q == LAST_IDX);

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_A     = out_a_q;
  assign bus.m_x     = out_x_q;
  assign frame_cnt   = frame_cnt_q;
  assign err         = err_q;
  assign dbg_state   = state_q;

  // Next-state: word packing, frame hand-off, delivery count and error flag.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    asm_a_d     = asm_a_q;
    asm_x_d     = asm_x_q;
    out_a_d     = out_a_q;
    out_x_d     = out_x_q;
    m_valid_d   = m_valid_q;
    frame_cnt_d = frame_cnt_q;
    err_set     = 1'b0;

    // A delivery empties the output unless a new frame is loaded below.
    if (drain) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
      m_valid_d   = 1'b0;
    end

    case (state_q)
      COLLECT: begin
        if (beat) begin
          if (bus.s_last != at_last) begin
            // Early last or missing last: drop the partial frame.
            err_set = 1'b1;
            wcnt_d  = '0;
          end else begin
            for (int i = 0; i < A_WORDS; i++) begin
              if (wcnt_q == WCNT_W'(i)) asm_a_d[i*WORD_W +: WORD_W] = bus.s_data;
            end
            for (int j = 0; j < X_WORDS; j++) begin
              if (wcnt_q == WCNT_W'(A_WORDS + j)) asm_x_d[j*WORD_W +: WORD_W] = bus.s_data;
            end
            if (at_last) begin
              wcnt_d = '0;
              if (!m_valid_q || drain) begin
                out_a_d   = asm_a_d;
                out_x_d   = asm_x_d;
                m_valid_d = 1'b1;
              end else begin
                state_d = FULL;
              end
            end else begin
              wcnt_d = wcnt_q + WCNT_W'(1);
            end
          end
        end
      end
      FULL: begin
        // Completed frame waits in the assembly buffer until the output frees.
        if (drain) begin
          out_a_d   = asm_a_q;
          out_x_d   = asm_x_q;
          m_valid_d = 1'b1;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    // A new error wins over a simultaneous clear.
    err_d = err_set || (err_q && !clr_err);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      wcnt_q      <= '0;
      asm_a_q     <= '0;
      asm_x_q     <= '0;
      out_a_q     <= '0;
      out_x_q     <= '0;
      m_valid_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      asm_a_q     <= asm_a_d;
      asm_x_q     <= asm_x_d;
      out_a_q     <= out_a_d;
      out_x_q     <= out_x_d;
      m_valid_q   <= m_valid_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/atax_operand_packer.md
Name: atax_operand_packer

Overview:
- Producer-side front end for the atax compute core.
- Accepts a serial 32-bit word stream over a valid/ready handshake and assembles one operand frame: the 512-bit A slice plus the 64-bit x slice.
- Presents completed frames on a valid/ready output whose data bus matches the core's A/x inputs; the core's `enable` is driven from the output handshake.
- Double-buffered (assembly register + output register), so collection of frame n+1 overlaps a stalled frame n.

Parameters:
- WORD_W, 32, input word width in bits.
- A_WORDS, 16, words per A slice (A_WORDS*WORD_W = 512).
- X_WORDS, 2, words per x slice (X_WORDS*WORD_W = 64).
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- s_valid  in  1  input word valid.
- s_ready  out  1  packer can accept a word.
- s_data  in  WORD_W  input word.
- s_last  in  1  marks final word of a frame.
- m_valid  out  1  packed frame available.
- m_ready  in  1  core accepts frame (core `enable` = m_valid & m_ready).
- m_A  out  A_WORDS*WORD_W  packed A slice.
- m_x  out  X_WORDS*WORD_W  packed x slice.
- frame_cnt  out  CNT_W  frames delivered, wraps to 0 after all-ones.
- err  out  1  sticky framing error.
- clr_err  in  1  synchronous clear of err.

Behaviour:
- Reset (reset=0, async): wcnt=0, state=COLLECT, s_ready=0 during reset. All outputs zero: m_valid=0, m_A=0, m_x=0, frame_cnt=0, err=0. Assembly buffer is also cleared to 0.
  - After reset deasserts, s_ready=1 on the first cycle.
  - Reset mid-frame discards the partial frame and any undelivered output frame.
- Word acceptance: a beat transfers on a rising edge with s_valid & s_ready. The word counter wcnt runs 0..F-1, where F = A_WORDS+X_WORDS = 18.
- Packing:
  - Beat k < A_WORDS writes assembly A bits [k*WORD_W +: WORD_W].
  - Beat k >= A_WORDS writes x bits [(k-A_WORDS)*WORD_W +: WORD_W].
  - Word 0 lands in the LSBs. No arithmetic; data is copied bit-exact.
- State machine:
  - COLLECT: s_ready=1. On an accepted beat with wcnt=F-1 and s_last=1, the frame is complete.
    - If the output register is empty, or is being drained this same edge (m_valid & m_ready): load the output register, set m_valid=1, wcnt=0, stay in COLLECT.
    - Otherwise go to FULL with wcnt=0.
  - FULL: s_ready=0. On the edge where m_valid & m_ready, the assembly buffer moves to the output register, m_valid stays 1, and the state returns to COLLECT.
- Output handshake:
  - m_valid stays high until accepted.
  - m_A and m_x are stable while m_valid=1 and m_ready=0.
  - Each m_valid & m_ready edge increments frame_cnt by 1 (modulo 2^CNT_W). With no new frame loaded that edge, m_valid falls to 0.
- Latency: last beat accepted at edge t with the output empty -> m_valid=1 after edge t (one cycle). Sustained throughput is one word per cycle with m_ready held high.
- Framing errors:
  - Triggers: an accepted beat with s_last=1 while wcnt != F-1, or an accepted beat with wcnt=F-1 and s_last=0.
  - Response: set err=1, discard the partial frame, wcnt=0. Nothing is emitted, frame_cnt is unchanged, and the next beat starts a new frame.
  - err stays set until clr_err=1 at a rising edge. If a new error occurs on the same edge as clr_err, err stays 1 (set wins).
- s_valid deasserted mid-frame: wcnt holds, with no timeout.

Test Plan:
- Reset, then 18 beats s_data=k+1 (k=0..17), s_last on beat 17, m_ready=1 -> m_valid high one cycle after beat 17.
  - m_A[31:0]=1, m_A[511:480]=16, m_x[31:0]=17, m_x[63:32]=18; frame_cnt=1.
- m_ready=0, stream 2 full frames back-to-back -> frame 1 held in the output register, frame 2 completes, packer enters FULL and s_ready=0.
  - Raise m_ready: frame 1 then frame 2 delivered on consecutive cycles, s_ready returns to 1, frame_cnt=2.
- s_last asserted on beat 5 -> err=1, no m_valid. Next 18-beat frame delivers correctly with frame_cnt unchanged+1; pulse clr_err -> err=0.
- Beat 17 without s_last -> err=1 and the frame is dropped; the following correct frame packs starting at word 0.
- Drop reset low at beat 9 of a frame while an older frame is pending on the output -> m_valid=0, frame_cnt=0, err=0 immediately. A subsequent full frame delivers normally.
- Preload frame_cnt to 16'hFFFF via 65535 frames (or force) and deliver one more frame -> frame_cnt wraps to 0.
